// File: rtl/adjust_ctrl_if.sv
// ---------------------------------------------------------------------------
// adjust_ctrl_if -- key inputs and mode/strobe outputs of the adjust controller.
//
// Signals
//   key_mode, key_shift, key_up, key_down : debounced active-high key levels
//   model        [1:0] : mode (00 clock, 01 alarm, 10 stopwatch, 11 adjust)
//   date_time_ch       : adjust sub-page (0 time, 1 date)
//   adjust_shif  [1:0] : digit-position select (00, 01, 10)
//   up_pulse, down_pulse : single-cycle increment/decrement strobes
//   timeout_flag       : single-cycle pulse on automatic return to clock mode
//
// Modports
//   master : key panel side, drives the keys and observes the outputs
//   slave  : the controller, reads the keys and drives the outputs
// ---------------------------------------------------------------------------
interface adjust_ctrl_if;
    logic       key_mode;
    logic       key_shift;
    logic       key_up;
    logic       key_down;
    logic [1:0] model;
    logic       date_time_ch;
    logic [1:0] adjust_shif;
    logic       up_pulse;
    logic       down_pulse;
    logic       timeout_flag;

    modport master (
        output key_mode, key_shift, key_up, key_down,
        input  model, date_time_ch, adjust_shif, up_pulse, down_pulse, timeout_flag
    );

    modport slave (
        input  key_mode, key_shift, key_up, key_down,
        output model, date_time_ch, adjust_shif, up_pulse, down_pulse, timeout_flag
    );
endinterface

// File: rtl/adjust_ctrl.sv
// ---------------------------------------------------------------------------
// adjust_ctrl -- mode / digit-select / up-down strobe controller for a clock
// front panel.
//
// Keys are registered once; a key action is a rising edge of the registered
// level. key_mode cycles the mode, key_shift walks the digit select (in alarm
// and adjust modes only), key_up/key_down produce one-cycle strobes. After
// TIMEOUT idle cycles in alarm/adjust mode the controller falls back to clock
// mode and pulses timeout_flag.
//
// Optional feature: define ADJ_AUTOREPEAT_EN to keep strobing while key_up or
// key_down is held alone (first repeat HOLD_DLY cycles after the initial
// strobe, then every REPEAT_PER cycles). Without it, one strobe per press and
// no hold/repeat counters exist.
//
// Ports
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : adjust_ctrl_if.slave (keys in, mode/strobes out)
// ---------------------------------------------------------------------------
module adjust_ctrl #(
    parameter int unsigned HOLD_DLY   = 50_000_000,
    parameter int unsigned REPEAT_PER = 10_000_000,
    parameter int unsigned TIMEOUT    = 500_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    adjust_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'b00,
        MODE_ALARM     = 2'b01,
        MODE_STOPWATCH = 2'b10,
        MODE_ADJUST    = 2'b11
    } mode_e;

    // Degenerate parameter values have no meaningful behaviour.
    if (HOLD_DLY < 1 || REPEAT_PER < 1 || TIMEOUT < 2) begin : g_bad_params
        $error("adjust_ctrl: need HOLD_DLY >= 1, REPEAT_PER >= 1, TIMEOUT >= 2");
    end

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

    // ---------------- key registers and edge detect ----------------
    logic [3:0] key_q;      // {mode, shift, up, down}
    logic [3:0] key_prev;
    logic [3:0] key_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= '0;
            key_prev <= '0;
        end else begin
            // NOTE: non-blocking, so key_prev captures the old key_q and the two form a pipeline.
            key_q    <= {bus.key_mode, bus.key_shift, bus.key_up, bus.key_down};
            key_prev <= key_q;
        end
    end

    assign key_rise = key_q & ~key_prev;

    logic mode_act, shift_act, up_act, down_act, up_lvl, down_lvl;
    assign mode_act  = key_rise[3];
    assign shift_act = key_rise[2];
    assign up_act    = key_rise[1];
    assign down_act  = key_rise[0];
    assign up_lvl    = key_q[1];
    assign down_lvl  = key_q[0];

    // ---------------- mode FSM ----------------
    mode_e mode, mode_next;
    logic  adj_mode, idle, to_fire;

    assign adj_mode = (mode == MODE_ALARM) || (mode == MODE_ADJUST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode <= MODE_CLOCK;
        else        mode <= mode_next;
    end

    // A mode key action always wins; a timeout can only land on a quiet cycle.
    always_comb begin
        // NOTE: default assignment first, so no path leaves mode_next unassigned (no latch).
        mode_next = mode;
        if (mode_act)     mode_next = mode_e'(mode + 2'd1);
        else if (to_fire) mode_next = MODE_CLOCK;
    end

    // ---------------- idle timeout ----------------
    logic [TO_W-1:0] idle_cnt;

    assign idle    = (key_q == 4'b0000);
    assign to_fire = adj_mode && idle && (idle_cnt == TO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              idle_cnt <= '0;
        else if (!adj_mode || !idle || to_fire)  idle_cnt <= '0;
        else if (idle_cnt != TO_MAX)             idle_cnt <= idle_cnt + 1'b1;
    end

    // ---------------- digit select and date/time page ----------------
    logic [1:0] shif_q;
    logic       dtc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shif_q <= 2'b00;
            dtc_q  <= 1'b0;
        end else if (mode_act || to_fire) begin
            shif_q <= 2'b00;
            dtc_q  <= 1'b0;
        end else if (shift_act && adj_mode) begin
            if (shif_q == 2'b10) begin
                shif_q <= 2'b00;
                // Only the adjust mode has a date page; alarm keeps it at 0.
                if (mode == MODE_ADJUST) dtc_q <= ~dtc_q;
            end else begin
                shif_q <= shif_q + 2'b01;
            end
        end
    end

    // ---------------- up/down strobes ----------------
    // A press counts only with the other key released and no mode/shift action.
    logic up_fire, down_fire, rpt_up, rpt_down;
    assign up_fire   = up_act   && !down_lvl && adj_mode && !mode_act && !shift_act;
    assign down_fire = down_act && !up_lvl   && adj_mode && !mode_act && !shift_act;

`ifdef ADJ_AUTOREPEAT_EN
    localparam int HD_W = (HOLD_DLY   > 1) ? $clog2(HOLD_DLY)   : 1;
    localparam int RP_W = (REPEAT_PER > 1) ? $clog2(REPEAT_PER) : 1;
    localparam logic [HD_W-1:0] HD_MAX = HD_W'(HOLD_DLY - 1);
    localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_PER - 1);

    logic [HD_W-1:0] hold_cnt;
    logic [RP_W-1:0] rpt_cnt;
    logic            arm_up, arm_down, repeating, keep, rpt_due;

    // Repeat survives only while the armed key stays held alone in the same mode.
    assign keep    = adj_mode && !mode_act &&
                     ((arm_up && up_lvl && !down_lvl) || (arm_down && down_lvl && !up_lvl));
    assign rpt_due = keep && (repeating ? (rpt_cnt == RP_MAX) : (hold_cnt == HD_MAX));
    // A shift action in the same cycle drops that repeat strobe but keeps the cadence.
    assign rpt_up   = rpt_due && arm_up   && !shift_act;
    assign rpt_down = rpt_due && arm_down && !shift_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_up <= 1'b0; arm_down <= 1'b0; repeating <= 1'b0;
            hold_cnt <= '0; rpt_cnt <= '0;
        end else if (up_fire || down_fire) begin
            arm_up <= up_fire; arm_down <= down_fire; repeating <= 1'b0;
            hold_cnt <= '0; rpt_cnt <= '0;
        end else if (keep) begin
            if (!repeating) begin
                if (hold_cnt == HD_MAX) repeating <= 1'b1;
                else                    hold_cnt  <= hold_cnt + 1'b1;
            end else if (rpt_cnt == RP_MAX) begin
                rpt_cnt <= '0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end else begin
            arm_up <= 1'b0; arm_down <= 1'b0; repeating <= 1'b0;
            hold_cnt <= '0; rpt_cnt <= '0;
        end
    end
`else
    assign rpt_up   = 1'b0;
    assign rpt_down = 1'b0;
`endif

    logic up_q, down_q, to_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            up_q   <= up_fire   || rpt_up;
            down_q <= down_fire || rpt_down;
            to_q   <= to_fire;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.model        = mode;
        bus.adjust_shif  = shif_q;
        bus.date_time_ch = dtc_q;
        bus.up_pulse     = up_q;
        bus.down_pulse   = down_q;
        bus.timeout_flag = to_q;
    end
endmodule
